// File: rtl/rx_control_module_if.sv
// Receive-path signal bundle between the edge detector / serial line and the byte consumer.
// The master side drives the line, strobe and enable; the slave side is the receive sequencer.
interface rx_control_module_if;
    logic       Rx_Pin_In;
    logic       H2L_Sig;
    logic       Rx_En_Sig;
    logic [7:0] Rx_Data;
    logic       Rx_Done_Sig;
    logic       Frame_Err_Sig;
    logic       Rx_Busy;

    modport master (
        output Rx_Pin_In,
        output H2L_Sig,
        output Rx_En_Sig,
        input  Rx_Data,
        input  Rx_Done_Sig,
        input  Frame_Err_Sig,
        input  Rx_Busy
    );

    modport slave (
        input  Rx_Pin_In,
        input  H2L_Sig,
        input  Rx_En_Sig,
        output Rx_Data,
        output Rx_Done_Sig,
        output Frame_Err_Sig,
        output Rx_Busy
    );
endinterface

// File: rtl/rx_control_module.sv
// UART receive sequencer: start-bit validation at mid-bit, 8 data bits LSB-first, one stop bit.
// Presents each good byte with a one-cycle done strobe, or a one-cycle framing-error strobe.
module rx_control_module #(
    parameter int unsigned BPS_CNT = 434
) (
    input logic                 CLK,
    input logic                 RSTn,
    rx_control_module_if.slave  rx_if
);

    localparam logic [8:0] LP_BPS_M1  = 9'(BPS_CNT - 1);
    localparam logic [8:0] LP_HALF_M1 = 9'((BPS_CNT / 2) - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StDone} state_e;

    state_e     r_state, w_state_d;
    logic [8:0] r_cnt, w_cnt_d;
    logic [2:0] r_idx, w_idx_d;
    logic [7:0] r_shift, w_shift_d;
    logic [7:0] r_data, w_data_d;
    logic       r_done, w_done_d;
    logic       r_err, w_err_d;
    logic       r_busy;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_idx   <= w_idx_d;
            r_shift <= w_shift_d;
            r_data  <= w_data_d;
            r_done  <= w_done_d;
            r_err   <= w_err_d;
            r_busy  <= (w_state_d != StIdle);
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_idx_d   = r_idx;
        w_shift_d = r_shift;
        w_data_d  = r_data;
        w_done_d  = 1'b0;
        w_err_d   = 1'b0;

        // Losing enable mid-frame wins over any sample point: abort silently.
        if (r_state != StIdle && !rx_if.Rx_En_Sig) begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
            w_idx_d   = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (rx_if.Rx_En_Sig && rx_if.H2L_Sig) begin
                        w_state_d = StStart;
                        w_cnt_d   = '0;
                    end
                end
                StStart: begin
                    if (r_cnt == LP_HALF_M1) begin
                        w_cnt_d   = '0;
                        w_idx_d   = '0;
                        w_state_d = rx_if.Rx_Pin_In ? StIdle : StData;
                    end else begin
                        w_cnt_d = r_cnt + 9'd1;
                    end
                end
                StData: begin
                    if (r_cnt == LP_BPS_M1) begin
                        w_shift_d[r_idx] = rx_if.Rx_Pin_In;
                        w_cnt_d          = '0;
                        w_idx_d          = r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
                            w_state_d = StStop;
                        end
                    end else begin
                        w_cnt_d = r_cnt + 9'd1;
                    end
                end
                StStop: begin
                    if (r_cnt == LP_BPS_M1) begin
                        w_cnt_d = '0;
                        if (rx_if.Rx_Pin_In) begin
                            w_state_d = StDone;
                            w_data_d  = r_shift;
                            w_done_d  = 1'b1;
                        end else begin
                            w_state_d = StIdle;
                            w_err_d   = 1'b1;
                        end
                    end else begin
                        w_cnt_d = r_cnt + 9'd1;
                    end
                end
                StDone: begin
                    w_state_d = StIdle;
                end
                default: begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                    w_idx_d   = '0;
                end
            endcase
        end
    end

    assign rx_if.Rx_Data       = r_data;
    assign rx_if.Rx_Done_Sig   = r_done;
    assign rx_if.Frame_Err_Sig = r_err;
    assign rx_if.Rx_Busy       = r_busy;

endmodule

// File: tb/tb_rx_control_module.sv
// Directed bench for rx_control_module at BPS_CNT=16 (HALF=8): good frames, back-to-back,
// start glitch, framing error, enable abort and asynchronous reset mid-frame.
module tb_rx_control_module;

    localparam int unsigned BPS = 16;

    logic CLK = 1'b0;
    logic RSTn;
    int   total = 0;
    int   bad   = 0;
    int   strobes;

    rx_control_module_if bus ();

    rx_control_module #(.BPS_CNT(BPS)) dut (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .rx_if (bus)
    );

    always #5 CLK = ~CLK;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives a frame whose edge 0 is the next rising edge, through edge last_edge.
    // Returns the number of cycles with a strobe seen before edge 152.
    task automatic frame(input logic [7:0] b, input logic stop_bit, input int last_edge,
                         output int n_strobe);
        int seg;
        n_strobe = 0;
        for (int e = 0; e <= last_edge; e++) begin
            seg = e / 16;
            if (seg == 0)      bus.Rx_Pin_In = 1'b0;
            else if (seg <= 8) bus.Rx_Pin_In = b[seg-1];
            else               bus.Rx_Pin_In = stop_bit;
            bus.H2L_Sig = (e == 0);
            tick();
            if (e != 152 && (bus.Rx_Done_Sig || bus.Frame_Err_Sig)) n_strobe++;
        end
        bus.H2L_Sig = 1'b0;
    endtask

    initial begin
        RSTn          = 1'b0;
        bus.Rx_Pin_In = 1'b1;
        bus.H2L_Sig   = 1'b0;
        bus.Rx_En_Sig = 1'b1;
        tick();
        tick();
        chk("rst_data", bus.Rx_Data, 8'h00);
        chk("rst_done", bus.Rx_Done_Sig, 1'b0);
        chk("rst_err",  bus.Frame_Err_Sig, 1'b0);
        chk("rst_busy", bus.Rx_Busy, 1'b0);
        RSTn = 1'b1;
        tick();

        // Good frame 0xA5: done strobe in the cycle after edge 152.
        frame(8'hA5, 1'b1, 152, strobes);
        chk("a5_early_strobe", strobes, 0);
        chk("a5_done",  bus.Rx_Done_Sig, 1'b1);
        chk("a5_data",  bus.Rx_Data, 8'hA5);
        chk("a5_err",   bus.Frame_Err_Sig, 1'b0);
        chk("a5_busy",  bus.Rx_Busy, 1'b1);
        bus.Rx_Pin_In = 1'b1;
        tick();
        chk("a5_done_off", bus.Rx_Done_Sig, 1'b0);
        chk("a5_busy_off", bus.Rx_Busy, 1'b0);

        // Back-to-back 0x00 then 0xFF, second start sampled the cycle after IDLE re-entry.
        frame(8'h00, 1'b1, 152, strobes);
        chk("b0_done", bus.Rx_Done_Sig, 1'b1);
        chk("b0_data", bus.Rx_Data, 8'h00);
        bus.Rx_Pin_In = 1'b1;
        tick();
        frame(8'hFF, 1'b1, 152, strobes);
        chk("b1_early_strobe", strobes, 0);
        chk("b1_done", bus.Rx_Done_Sig, 1'b1);
        chk("b1_data", bus.Rx_Data, 8'hFF);
        bus.Rx_Pin_In = 1'b1;
        tick();
        tick();

        // Glitch: line low for edges 0..2 only; start sample at edge 8 reads 1.
        strobes = 0;
        for (int e = 0; e <= 12; e++) begin
            bus.Rx_Pin_In = (e >= 3);
            bus.H2L_Sig   = (e == 0);
            tick();
            if (bus.Rx_Done_Sig || bus.Frame_Err_Sig) strobes++;
            if (e == 1) chk("gl_busy_start", bus.Rx_Busy, 1'b1);
            if (e == 7) chk("gl_busy_pre",   bus.Rx_Busy, 1'b1);
            if (e == 8) chk("gl_busy_idle",  bus.Rx_Busy, 1'b0);
        end
        chk("gl_strobes", strobes, 0);
        chk("gl_data", bus.Rx_Data, 8'hFF);

        // Framing error on 0x3C: error strobe, no done, data held, busy drops.
        frame(8'h3C, 1'b0, 152, strobes);
        chk("fe_early_strobe", strobes, 0);
        chk("fe_err",  bus.Frame_Err_Sig, 1'b1);
        chk("fe_done", bus.Rx_Done_Sig, 1'b0);
        chk("fe_data", bus.Rx_Data, 8'hFF);
        chk("fe_busy", bus.Rx_Busy, 1'b0);
        tick();
        chk("fe_err_off", bus.Frame_Err_Sig, 1'b0);
        chk("fe_stay_idle", bus.Rx_Busy, 1'b0);
        bus.Rx_Pin_In = 1'b1;
        tick();

        // Enable dropped, sampled at edge 60: abort silently.
        frame(8'h77, 1'b1, 59, strobes);
        chk("ab_busy_pre", bus.Rx_Busy, 1'b1);
        bus.Rx_En_Sig = 1'b0;
        tick();
        chk("ab_busy", bus.Rx_Busy, 1'b0);
        strobes = 0;
        bus.Rx_Pin_In = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.H2L_Sig = (i == 3);
            tick();
            if (bus.Rx_Done_Sig || bus.Frame_Err_Sig || bus.Rx_Busy) strobes++;
        end
        chk("ab_quiet", strobes, 0);
        chk("ab_data", bus.Rx_Data, 8'hFF);
        bus.Rx_En_Sig = 1'b1;
        tick();
        frame(8'h5A, 1'b1, 152, strobes);
        chk("ab_5a_done", bus.Rx_Done_Sig, 1'b1);
        chk("ab_5a_data", bus.Rx_Data, 8'h5A);
        bus.Rx_Pin_In = 1'b1;
        tick();
        tick();

        // Asynchronous reset between edges 99 and 100, checked before any further edge.
        frame(8'hC3, 1'b1, 99, strobes);
        #2;
        RSTn = 1'b0;
        #1;
        chk("ar_data", bus.Rx_Data, 8'h00);
        chk("ar_busy", bus.Rx_Busy, 1'b0);
        chk("ar_done", bus.Rx_Done_Sig, 1'b0);
        chk("ar_err",  bus.Frame_Err_Sig, 1'b0);
        bus.Rx_Pin_In = 1'b1;
        tick();
        #2;
        RSTn = 1'b1;
        tick();
        tick();
        frame(8'h81, 1'b1, 152, strobes);
        chk("ar_81_strobe", strobes, 0);
        chk("ar_81_done", bus.Rx_Done_Sig, 1'b1);
        chk("ar_81_data", bus.Rx_Data, 8'h81);
        bus.Rx_Pin_In = 1'b1;
        tick();
        chk("ar_81_idle", bus.Rx_Busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
